// File: rtl/lcd_write_queue.sv
// Buffers CPU writes to the LCD window and replays them to an HD44780-type
// display with setup/strobe timing and per-command execution delays.
module lcd_write_queue #(
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 1,
  parameter int EXEC_SHORT = 40,
  parameter int EXEC_LONG  = 1400
) (
  input  logic                     E,
  input  logic                     Reset,
  input  logic                     WrStb,
  input  logic                     WrRS,
  input  logic [7:0]               WrData,
  input  logic                     ClrOvf,
  output logic [7:0]               LcdD,
  output logic                     LcdRS,
  output logic                     LcdRW,
  output logic                     LcdEn,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Full,
  output logic                     Busy,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(EXEC_LONG + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} SeqState;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] cnt;
  SeqState       state;
  logic          push;
  logic          drop;
  logic          pop;
  logic          longCmd;

  assign Full    = (Level == LW'(DEPTH));
  assign Busy    = (Level != '0) || (state != IDLE);
  assign LcdRW   = 1'b0;
  assign push    = WrStb && !Full;
  assign drop    = WrStb && Full;
  assign pop     = (state == IDLE) && (Level != '0);
  // Clear ($01) and home ($02/$03) need the long execution delay.
  assign longCmd = !LcdRS && (LcdD[7:2] == 6'd0) && (LcdD != 8'd0);

  always_ff @(posedge E) begin
    if (push) begin
      mem[wrPtr] <= {WrRS, WrData};
    end
  end

  always_ff @(posedge E) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      Level    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   Level <= Level + 1'b1;
        2'b01:   Level <= Level - 1'b1;
        default: Level <= Level;
      endcase
      if (drop) begin
        Overflow <= 1'b1;
      end else if (ClrOvf) begin
        Overflow <= 1'b0;
      end
    end
  end

  // LcdD/LcdRS load only when leaving IDLE, keeping them stable through HOLD.
  always_ff @(posedge E) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      LcdEn <= 1'b0;
      LcdD  <= 8'h00;
      LcdRS <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          LcdEn <= 1'b0;
          if (pop) begin
            {LcdRS, LcdD} <= mem[rdPtr];
            cnt           <= CW'(SETUP_CYC - 1);
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            LcdEn <= 1'b1;
            cnt   <= CW'(PULSE_CYC - 1);
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            LcdEn <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          cnt   <= longCmd ? CW'(EXEC_LONG - 1) : CW'(EXEC_SHORT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          LcdEn <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_queue.sv
// Testbench for lcd_write_queue: directed vectors, corner-case sequences and
// random traffic checked against a timestamp-based reference model.
module tb_lcd_write_queue;

  localparam int DEPTH      = 4;
  localparam int SETUP_CYC  = 1;
  localparam int PULSE_CYC  = 1;
  localparam int EXEC_SHORT = 40;
  localparam int EXEC_LONG  = 1400;
  localparam int MAXE       = 1024;

  logic       E = 1'b0;
  logic       Reset = 1'b0;
  logic       WrStb = 1'b0;
  logic       WrRS = 1'b0;
  logic [7:0] WrData = 8'h00;
  logic       ClrOvf = 1'b0;
  logic [7:0] LcdD;
  logic       LcdRS;
  logic       LcdRW;
  logic       LcdEn;
  logic [2:0] Level;
  logic       Full;
  logic       Busy;
  logic       Overflow;

  always #5 E = ~E;

  lcd_write_queue #(
    .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
    .EXEC_SHORT(EXEC_SHORT), .EXEC_LONG(EXEC_LONG)
  ) dut (
    .E(E), .Reset(Reset), .WrStb(WrStb), .WrRS(WrRS), .WrData(WrData),
    .ClrOvf(ClrOvf), .LcdD(LcdD), .LcdRS(LcdRS), .LcdRW(LcdRW), .LcdEn(LcdEn),
    .Level(Level), .Full(Full), .Busy(Busy), .Overflow(Overflow)
  );

  int         edgeNum = 0;
  int         checks = 0;
  int         errors = 0;
  int         mPush [MAXE];
  int         mPop  [MAXE];
  int         mPer  [MAXE];
  logic       mRS   [MAXE];
  logic [7:0] mD    [MAXE];
  int         mN = 0;
  int         nextFree = 0;
  logic       mOvf = 1'b0;
  logic       prevEn = 1'b0;
  logic [8:0] seen [$];
  int         riseEdge [$];

  typedef struct {
    logic       rst;
    logic       stb;
    logic       rs;
    logic [7:0] d;
    logic [2:0] expLevel;
    logic       expEn;
    logic       expRS;
    logic [7:0] expD;
    logic       expBusy;
  } vec_t;

  vec_t vecs [20];

  function automatic int execOf(input logic rs, input logic [7:0] d);
    if (!rs && d >= 8'd1 && d <= 8'd3) return EXEC_LONG;
    return EXEC_SHORT;
  endfunction

  function automatic int modelLevel(input int t);
    int n = 0;
    for (int i = 0; i < mN; i++)
      if (mPush[i] <= t && t < mPop[i]) n++;
    return n;
  endfunction

  // Each accepted byte gets its pop edge from the time the LCD next becomes free.
  function automatic void modelEdge(input logic rst, input logic stb, input logic rs,
                                    input logic [7:0] d, input logic clr);
    int  t = edgeNum;
    bit  full;
    if (rst) begin
      mN = 0;
      nextFree = t + 1;
      mOvf = 1'b0;
      return;
    end
    full = (modelLevel(t - 1) == DEPTH);
    if (stb && full) begin
      mOvf = 1'b1;
    end else begin
      if (stb && mN < MAXE) begin
        mPush[mN] = t;
        mPop[mN]  = (t + 1 > nextFree) ? t + 1 : nextFree;
        mPer[mN]  = 2 + SETUP_CYC + PULSE_CYC + execOf(rs, d);
        mRS[mN]   = rs;
        mD[mN]    = d;
        nextFree  = mPop[mN] + mPer[mN];
        mN++;
      end
      if (clr) mOvf = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNum, act, exp);
    end
  endtask

  task automatic checkModel();
    int         t = edgeNum;
    int         lvl = 0;
    logic       busy = 1'b0;
    logic       en = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] d = 8'h00;
    for (int i = 0; i < mN; i++) begin
      if (mPush[i] <= t && t < mPop[i]) lvl++;
      if (mPush[i] <= t && t < mPop[i] + mPer[i] - 1) busy = 1'b1;
      if (mPop[i] + SETUP_CYC <= t && t < mPop[i] + SETUP_CYC + PULSE_CYC) en = 1'b1;
      if (mPop[i] <= t) begin
        d  = mD[i];
        rs = mRS[i];
      end
    end
    checkOutput("model_level", Level, lvl);
    checkOutput("model_full", Full, (lvl == DEPTH) ? 1 : 0);
    checkOutput("model_busy", Busy, busy);
    checkOutput("model_en", LcdEn, en);
    checkOutput("model_d", LcdD, d);
    checkOutput("model_rs", LcdRS, rs);
    checkOutput("model_rw", LcdRW, 0);
    checkOutput("model_ovf", Overflow, mOvf);
  endtask

  task automatic applyStimulus(input logic rst, input logic stb, input logic rs,
                               input logic [7:0] d, input logic clr);
    Reset = rst; WrStb = stb; WrRS = rs; WrData = d; ClrOvf = clr;
    @(posedge E);
    edgeNum++;
    modelEdge(rst, stb, rs, d, clr);
    #1;
    Reset = 1'b0; WrStb = 1'b0; ClrOvf = 1'b0;
    if (LcdEn === 1'b1 && prevEn !== 1'b1) begin
      seen.push_back({LcdRS, LcdD});
      riseEdge.push_back(edgeNum);
    end
    prevEn = LcdEn;
    checkModel();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic writeByte(input logic rs, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, rs, d, 1'b0);
  endtask

  task automatic waitIdle(input int maxCyc);
    int i = 0;
    while (Busy !== 1'b0 && i < maxCyc) begin
      idle(1);
      i++;
    end
    checkOutput("wait_idle_timeout", Busy, 0);
  endtask

  // Clear/home commands stretch the gap between strobes to the long delay.
  task automatic measurePair(input logic [7:0] cmd, input int expGap);
    seen.delete();
    riseEdge.delete();
    writeByte(1'b0, cmd);
    writeByte(1'b1, 8'h42);
    waitIdle(3000);
    checkOutput($sformatf("pair_count_%02h", cmd), riseEdge.size(), 2);
    if (riseEdge.size() == 2) begin
      checkOutput($sformatf("pair_gap_%02h", cmd), riseEdge[1] - riseEdge[0], expGap);
      checkOutput($sformatf("pair_first_%02h", cmd), seen[0], {1'b0, cmd});
      checkOutput($sformatf("pair_second_%02h", cmd), seen[1], 9'h142);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", edgeNum);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         maxLvl;
    int         e1;
    logic [8:0] expv;
    logic       rs;

    for (int i = 0; i < 20; i++)
      vecs[i] = '{rst: (i == 0), stb: (i == 9), rs: (i == 9),
                  d: (i == 9) ? 8'h41 : 8'h00, expLevel: (i == 9) ? 3'd1 : 3'd0,
                  expEn: (i == 11), expRS: (i >= 10), expD: (i >= 10) ? 8'h41 : 8'h00,
                  expBusy: (i >= 9)};

    $display("[TB] directed vectors: single data write at edge 10");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stb, vecs[i].rs, vecs[i].d, 1'b0);
      checkOutput($sformatf("vec%0d_level", i), Level, vecs[i].expLevel);
      checkOutput($sformatf("vec%0d_en", i), LcdEn, vecs[i].expEn);
      checkOutput($sformatf("vec%0d_rs", i), LcdRS, vecs[i].expRS);
      checkOutput($sformatf("vec%0d_d", i), LcdD, vecs[i].expD);
      checkOutput($sformatf("vec%0d_busy", i), Busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_ovf", i), Overflow, 0);
    end
    idle(53 - edgeNum);
    checkOutput("busy_at_53", Busy, 1);
    idle(1);
    checkOutput("busy_at_54", Busy, 0);

    $display("[TB] clear/home execution timing");
    measurePair(8'h01, 1404);
    measurePair(8'h02, 1404);
    measurePair(8'h03, 1404);
    measurePair(8'h00, 44);
    measurePair(8'h04, 44);

    $display("[TB] overflow from six consecutive strobes");
    seen.delete();
    maxLvl = 0;
    for (int i = 0; i < 6; i++) begin
      writeByte(1'b1, 8'(8'hA0 + i));
      if (int'(Level) > maxLvl) maxLvl = int'(Level);
    end
    checkOutput("ovf_peak_level", maxLvl, 4);
    checkOutput("ovf_flag_set", Overflow, 1);
    waitIdle(1000);
    checkOutput("ovf_emitted", seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++) begin
      expv = {1'b1, 8'(8'hA0 + i)};
      checkOutput($sformatf("ovf_order%0d", i), seen[i], expv);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("ovf_cleared", Overflow, 0);

    $display("[TB] write on the pop edge while full");
    seen.delete();
    e1 = edgeNum + 1;
    for (int i = 0; i < 5; i++) writeByte(1'b1, 8'(8'hB0 + i));
    checkOutput("full_reached", Full, 1);
    idle(e1 + 44 - edgeNum);
    checkOutput("full_pre_ovf", Overflow, 0);
    writeByte(1'b1, 8'hBF);
    checkOutput("full_pop_drop", Overflow, 1);
    checkOutput("full_pop_level", Level, 3);
    idle(e1 + 88 - edgeNum);
    writeByte(1'b1, 8'hC0);
    checkOutput("lvl3_pop_keep", Level, 3);
    waitIdle(2000);
    checkOutput("full_emitted", seen.size(), 6);
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      expv = (i < 5) ? {1'b1, 8'(8'hB0 + i)} : 9'h1C0;
      checkOutput($sformatf("full_order%0d", i), seen[i], expv);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] reset during strobe");
    for (int i = 0; i < 3; i++) writeByte(1'b1, 8'(8'hD0 + i));
    checkOutput("strobe_en_high", LcdEn, 1);
    checkOutput("strobe_level", Level, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rst_en", LcdEn, 0);
    checkOutput("rst_level", Level, 0);
    checkOutput("rst_busy", Busy, 0);
    riseEdge.delete();
    idle(100);
    checkOutput("rst_no_strobes", riseEdge.size(), 0);

    $display("[TB] pointer wrap with 20 paced bytes");
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      writeByte((i % 4 == 0) ? 1'b0 : 1'b1, 8'(i));
      idle(49);
    end
    waitIdle(200);
    checkOutput("wrap_count", seen.size(), 20);
    for (int i = 0; i < seen.size() && i < 20; i++) begin
      rs = (i % 4 == 0) ? 1'b0 : 1'b1;
      expv = {rs, 8'(i)};
      checkOutput($sformatf("wrap_byte%0d", i), seen[i], expv);
    end
    checkOutput("wrap_no_ovf", Overflow, 0);

    $display("[TB] random traffic against reference model");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 11) == 0,
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 49) == 0);
    waitIdle(8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
